// File: rtl/bf_cpu_v2.sv
// Brainfuck-style execution core: one opcode byte per fetch, one data cell
// per access, blocking console handshakes and a hardware loop stack.
// Optional build macro BF_RLE_FOLD_EN: folds runs of '+'/'-' into a single
// read-modify-write by fetching ahead and accumulating the delta.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// FETCH      | drive IA=PC, IEN=1, advance PC
// FWAIT      | opcode arrives on IDIN, latch it
// DECODE     | dispatch opcode (or extend an RLE run)
// DREAD      | DEN=1, DWE=0 read of the current cell
// DWAIT      | read data arrives on DDIN, latch it
// MODIFY     | apply accumulated delta to the cell
// WRITE      | DEN=DWE=1 write-back of the cell
// LOOPCHK    | '[' push / skip, ']' jump / pop, stack fault detection
// SEEK       | skip-mode decode: track bracket nesting only
// COUT       | wait for CRDY, then emit cell[7:0] with a CWR pulse
// CIN        | wait for CRDA, ack and capture the console byte
// HALTED     | stopped until RESET

module bf_cpu_v2 #(
   parameter int IA_WIDTH        = 11,
   parameter int DA_WIDTH        = 11,
   parameter int DD_WIDTH        = 8,
   parameter int STACK_DEPTH_POW = 7
) (
   input  logic                CLK,
   input  logic                RESET,
   output logic [IA_WIDTH-1:0] IA,
   output logic                IEN,
   input  logic [7:0]          IDIN,
   output logic [DA_WIDTH-1:0] DA,
   output logic                DEN,
   output logic                DWE,
   output logic [DD_WIDTH-1:0] DDOUT,
   input  logic [DD_WIDTH-1:0] DDIN,
   input  logic [7:0]          CIN,
   input  logic                CRDA,
   output logic                CACK,
   output logic [7:0]          COUT,
   output logic                CWR,
   input  logic                CRDY,
   output logic                HALT,
   output logic                ERR
);

   localparam int STACK_DEPTH = 1 << STACK_DEPTH_POW;
   localparam int SP_W        = STACK_DEPTH_POW + 1;
   localparam int SEEK_W      = IA_WIDTH + 1;

   localparam logic [7:0] OP_INC  = 8'h2B;
   localparam logic [7:0] OP_DEC  = 8'h2D;
   localparam logic [7:0] OP_RGT  = 8'h3E;
   localparam logic [7:0] OP_LFT  = 8'h3C;
   localparam logic [7:0] OP_LOOP = 8'h5B;
   localparam logic [7:0] OP_END  = 8'h5D;
   localparam logic [7:0] OP_OUT  = 8'h2E;
   localparam logic [7:0] OP_IN   = 8'h2C;
   localparam logic [7:0] OP_HALT = 8'h00;

   typedef enum logic [3:0] {
      ST_FETCH, ST_FWAIT, ST_DECODE, ST_DREAD, ST_DWAIT, ST_MODIFY,
      ST_WRITE, ST_LOOPCHK, ST_SEEK, ST_COUT, ST_CIN, ST_HALTED
   } state_t;

   state_t                state_q, state_d;
   logic [IA_WIDTH-1:0]   pc_q, pc_d;
   logic [DA_WIDTH-1:0]   dc_q, dc_d;
   logic [7:0]            instr_q, instr_d;
   logic [DD_WIDTH-1:0]   cell_q, cell_d;
   logic [DD_WIDTH-1:0]   run_acc_q, run_acc_d;
   logic [SP_W-1:0]       sp_q, sp_d;
   logic [SEEK_W-1:0]     seek_cnt_q, seek_cnt_d;
   logic                  fold_q, fold_d;
   logic [7:0]            cout_q, cout_d;
   logic                  cwr_q, cwr_d;
   logic                  err_q, err_d;

   logic                  ien_c, den_c, dwe_c, cack_c;
   logic                  push_en;
   logic [IA_WIDTH-1:0]   stack_mem [STACK_DEPTH];
   logic [STACK_DEPTH_POW-1:0] top_idx;

   function automatic logic is_arith(input logic [7:0] op);
      return (op == OP_INC) || (op == OP_DEC);
   endfunction

   function automatic logic [DD_WIDTH-1:0] op_delta(input logic [7:0] op);
      return (op == OP_INC) ? DD_WIDTH'(1) : {DD_WIDTH{1'b1}};
   endfunction

   assign top_idx = STACK_DEPTH_POW'(sp_q - SP_W'(1));

   // Next-state, datapath updates and bus strobes
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      dc_d       = dc_q;
      instr_d    = instr_q;
      cell_d     = cell_q;
      run_acc_d  = run_acc_q;
      sp_d       = sp_q;
      seek_cnt_d = seek_cnt_q;
      fold_d     = fold_q;
      cout_d     = cout_q;
      cwr_d      = 1'b0;
      err_d      = err_q;
      ien_c      = 1'b0;
      den_c      = 1'b0;
      dwe_c      = 1'b0;
      cack_c     = 1'b0;
      push_en    = 1'b0;
      case (state_q)
         ST_FETCH: begin
            ien_c   = 1'b1;
            pc_d    = pc_q + IA_WIDTH'(1);
            state_d = ST_FWAIT;
         end
         ST_FWAIT: begin
            instr_d = IDIN;
            state_d = (seek_cnt_q != '0) ? ST_SEEK : ST_DECODE;
         end
         ST_DECODE: begin
            if (fold_q) begin
               // RLE run in progress: keep accumulating or flush the write
               if (is_arith(instr_q)) begin
                  run_acc_d = run_acc_q + op_delta(instr_q);
                  state_d   = ST_FETCH;
               end else begin
                  state_d   = ST_MODIFY;
               end
            end else begin
               case (instr_q)
                  OP_RGT: begin
                     dc_d    = dc_q + DA_WIDTH'(1);
                     state_d = ST_FETCH;
                  end
                  OP_LFT: begin
                     dc_d    = dc_q - DA_WIDTH'(1);
                     state_d = ST_FETCH;
                  end
                  OP_INC, OP_DEC, OP_OUT, OP_LOOP, OP_END: state_d = ST_DREAD;
                  OP_IN:   state_d = ST_CIN;
                  OP_HALT: state_d = ST_HALTED;
                  default: state_d = ST_FETCH;
               endcase
            end
         end
         ST_DREAD: begin
            den_c   = 1'b1;
            state_d = ST_DWAIT;
         end
         ST_DWAIT: begin
            cell_d = DDIN;
            if (is_arith(instr_q)) begin
               run_acc_d = op_delta(instr_q);
`ifdef BF_RLE_FOLD_EN
               fold_d    = 1'b1;
               state_d   = ST_FETCH;
`else
               state_d   = ST_MODIFY;
`endif
            end else if (instr_q == OP_OUT) begin
               state_d = ST_COUT;
            end else begin
               state_d = ST_LOOPCHK;
            end
         end
         ST_MODIFY: begin
            cell_d  = cell_q + run_acc_q;
            state_d = ST_WRITE;
         end
         ST_WRITE: begin
            den_c = 1'b1;
            dwe_c = 1'b1;
            // After a folded run the terminating opcode is already in instr_q
            if (fold_q) begin
               fold_d    = 1'b0;
               run_acc_d = '0;
               state_d   = ST_DECODE;
            end else begin
               state_d   = ST_FETCH;
            end
         end
         ST_LOOPCHK: begin
            state_d = ST_FETCH;
            if (instr_q == OP_LOOP) begin
               if (cell_q == '0) begin
                  seek_cnt_d = SEEK_W'(1);
               end else if (sp_q == SP_W'(STACK_DEPTH)) begin
                  err_d   = 1'b1;
                  state_d = ST_HALTED;
               end else begin
                  push_en = 1'b1;
                  sp_d    = sp_q + SP_W'(1);
               end
            end else begin
               if (sp_q == '0) begin
                  err_d   = 1'b1;
                  state_d = ST_HALTED;
               end else if (cell_q != '0) begin
                  pc_d = stack_mem[top_idx];
               end else begin
                  sp_d = sp_q - SP_W'(1);
               end
            end
         end
         ST_SEEK: begin
            state_d = ST_FETCH;
            case (instr_q)
               OP_LOOP: seek_cnt_d = seek_cnt_q + SEEK_W'(1);
               OP_END:  seek_cnt_d = seek_cnt_q - SEEK_W'(1);
               OP_HALT: begin
                  err_d   = 1'b1;
                  state_d = ST_HALTED;
               end
               default: seek_cnt_d = seek_cnt_q;
            endcase
         end
         ST_COUT: begin
            if (CRDY) begin
               cout_d  = cell_q[7:0];
               cwr_d   = 1'b1;
               state_d = ST_FETCH;
            end
         end
         ST_CIN: begin
            if (CRDA) begin
               cack_c  = 1'b1;
               cell_d  = DD_WIDTH'(CIN);
               state_d = ST_WRITE;
            end
         end
         ST_HALTED: state_d = ST_HALTED;
         default:   state_d = ST_FETCH;
      endcase
   end

   // Architectural state registers with synchronous reset
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q    <= ST_FETCH;
         pc_q       <= '0;
         dc_q       <= '0;
         instr_q    <= '0;
         cell_q     <= '0;
         run_acc_q  <= '0;
         sp_q       <= '0;
         seek_cnt_q <= '0;
         fold_q     <= 1'b0;
         cout_q     <= '0;
         cwr_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         dc_q       <= dc_d;
         instr_q    <= instr_d;
         cell_q     <= cell_d;
         run_acc_q  <= run_acc_d;
         sp_q       <= sp_d;
         seek_cnt_q <= seek_cnt_d;
         fold_q     <= fold_d;
         cout_q     <= cout_d;
         cwr_q      <= cwr_d;
         err_q      <= err_d;
      end
   end

   // Loop stack storage; contents are don't-care below the stack pointer
   always_ff @(posedge CLK) begin
      if (push_en) begin
         stack_mem[sp_q[STACK_DEPTH_POW-1:0]] <= pc_q;
      end
   end

   // Strobes are masked during RESET so an abandoned operation emits nothing
   assign IEN   = ien_c  & ~RESET;
   assign DEN   = den_c  & ~RESET;
   assign DWE   = dwe_c  & ~RESET;
   assign CACK  = cack_c & ~RESET;
   assign CWR   = cwr_q;
   assign IA    = pc_q;
   assign DA    = dc_q;
   assign DDOUT = cell_q;
   assign COUT  = cout_q;
   assign HALT  = (state_q == ST_HALTED);
   assign ERR   = err_q;

endmodule

// File: doc/bf_cpu_v2.md
BF_CPU_V2 -- requirements
Module: bf_cpu_v2

Interface
REQ-001 SHALL provide parameter IA_WIDTH, default 11, instruction address width.
REQ-002 SHALL provide parameter DA_WIDTH, default 11, data address width.
REQ-003 SHALL provide parameter DD_WIDTH, default 8, cell width; legal values are 8 to 32.
REQ-004 SHALL provide parameter STACK_DEPTH_POW, default 7, loop stack depth of 2^STACK_DEPTH_POW entries.
REQ-005 SHALL have port CLK  in  1  single clock; all logic is rising-edge.
REQ-006 SHALL have port RESET  in  1  synchronous, active-high reset.
REQ-007 SHALL have ports IA out IA_WIDTH (fetch address), IEN out 1 (fetch strobe) and IDIN in 8 (opcode byte, valid the cycle after IEN).
REQ-008 SHALL have ports DA out DA_WIDTH (cell address), DEN out 1 (access strobe), DWE out 1 (write qualifier), DDOUT out DD_WIDTH (write data) and DDIN in DD_WIDTH (read data, valid the cycle after DEN with DWE=0).
REQ-009 SHALL have ports CIN in 8, CRDA in 1, CACK out 1 (console input) and COUT out 8, CWR out 1, CRDY in 1 (console output).
REQ-010 SHALL have ports HALT out 1 (core stopped) and ERR out 1 (stopped on fault).

Function
REQ-011 SHALL decode ASCII '+' 2B, '-' 2D, '>' 3E, '<' 3C, '[' 5B, ']' 5D, '.' 2E, ',' 2C and 00 (halt); every other byte is a 3-cycle no-op.
REQ-012 SHALL use states FETCH, FWAIT, DECODE, DREAD, DWAIT, MODIFY, WRITE, LOOPCHK, SEEK, COUT, CIN, HALTED, each lasting one cycle unless stated.
REQ-013 FETCH SHALL drive IA=PC and IEN=1 for exactly one cycle, then increment PC modulo 2^IA_WIDTH.
REQ-014 '>'/'<' SHALL step DC by +1/-1 modulo 2^DA_WIDTH in DECODE and return to FETCH (3 cycles total).
REQ-015 '+'/'-' SHALL read the cell (DEN=1, DWE=0), add the signed delta modulo 2^DD_WIDTH and write back with DEN=DWE=1 for one cycle.
REQ-016 '.' SHALL read the cell, wait in COUT until CRDY=1, then load COUT with cell[7:0] and pulse CWR for exactly one cycle.
REQ-017 ',' SHALL wait in CIN until CRDA=1, pulse CACK for one cycle, and write CIN zero-extended to DD_WIDTH to the current cell.
REQ-018 '[' with a nonzero cell SHALL push PC (the address after '[') onto the loop stack.
REQ-019 '[' with a zero cell SHALL enter SEEK with nesting count 1: +1 per '[', -1 per ']', resume normal fetch after the ']' that reaches 0, and execute no other opcode meanwhile.
REQ-020 ']' with a nonzero cell SHALL load PC from the stack top without popping; ']' with a zero cell SHALL pop.
REQ-021 A push onto a full stack, a ']' on an empty stack, or a 00 byte fetched during SEEK SHALL set ERR=1 and HALT=1 and enter HALTED.
REQ-022 Opcode 00 outside SEEK SHALL enter HALTED with HALT=1 and ERR=0.
REQ-023 HALTED SHALL be left only by RESET; in HALTED, IEN, DEN, DWE, CWR and CACK SHALL stay 0.
REQ-024 IEN, DEN, CWR and CACK SHALL each be one-cycle pulses, and at most one of IEN and DEN SHALL be high in any cycle.
REQ-025 A push in the same cycle that a ']' is decoded cannot occur; stack operations are strictly serialised by the FSM.

Reset
REQ-026 RESET SHALL force state FETCH; PC, DC and stack pointer to 0; IA and COUT to 0; IEN, DEN, DWE, CWR, CACK, HALT and ERR to 0; and the seek count and run accumulator to 0.
REQ-027 RESET asserted mid-operation, including during COUT/CIN waits or SEEK, SHALL abandon the operation with no further bus or console strobe.

Configuration
REQ-028 Macro BF_RLE_FOLD_EN SHALL, when defined, fold runs of consecutive '+'/'-': after the cell read, the core fetches ahead and accumulates delta modulo 2^DD_WIDTH until a non-'+'/'-' opcode arrives, performs one write, then decodes that opcode without refetching it.
REQ-029 Without BF_RLE_FOLD_EN, each '+'/'-' SHALL perform its own read-modify-write; the architectural results SHALL be identical in both builds.

Verification
REQ-030 Program "+++." at CRDY=1 -> one CWR pulse with COUT=03; without RLE, 3 writes of 01,02,03; with RLE, one write of 03.
REQ-031 Program "-." on a zero cell, DD_WIDTH=8 -> COUT=FF; with DD_WIDTH=16 -> cell=FFFF and COUT=FF.
REQ-032 Program "++[->+<]>." -> COUT=02 and the loop body executes exactly twice.
REQ-033 Program "[[+]+]." on a zero cell -> SEEK skips the nested loop, no data write occurs, and COUT=00.
REQ-034 Program of 2^STACK_DEPTH_POW+1 nested '[' on a nonzero cell -> ERR=HALT=1 and no further IEN; "]" alone -> ERR=1.
REQ-035 Program ",." with CRDA raised 5 cycles late, CIN=41 -> one CACK pulse, then COUT=41; RESET asserted during the CRDY wait -> all strobes 0 on the next cycle.
